// File: rtl/fft_mem_pkg.sv
// Shared constants, control-state bundle and address bit-reversal
// for the FFT ping-pong frame memory.
package fft_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef struct packed {
    logic load_full;
    logic core_busy;
    logic bank_sel;
    logic core_start;
    logic overflow_err;
  } ctrl_t;

  // Reverse the low w bits of a (w <= 16).
  function automatic logic [15:0] bitrev(
    input logic [15:0] a,
    input int unsigned w
  );
    logic [15:0] r;
    r = {<<{a}};
    return r >> (16 - w);
  endfunction

endpackage

// File: rtl/fft_mem_bank.sv
// One DEPTH x DATA_W bank: two registered read ports, three write ports
// (1, 2 = core with 2 winning a collision; l = load port, lowest priority).
module fft_mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              wr_en_2,
  input  logic [ADDR_W-1:0] wr_addr_2,
  input  logic [DATA_W-1:0] wr_data_2,
  input  logic              wr_en_l,
  input  logic [ADDR_W-1:0] wr_addr_l,
  input  logic [DATA_W-1:0] wr_data_l,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_l) mem[wr_addr_l] <= wr_data_l;
    if (wr_en_1) mem[wr_addr_1] <= wr_data_1;
    if (wr_en_2) mem[wr_addr_2] <= wr_data_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_1 <= '0;
      rd_data_2 <= '0;
    end else begin
      rd_data_1 <= mem[rd_addr_1];
      rd_data_2 <= mem[rd_addr_2];
    end
  end

endmodule

// File: rtl/fft_pingpong_mem.sv
// Ping-pong frame memory: load port fills one bank while the core
// works in the other; banks swap when load is full and core is idle.
module fft_pingpong_mem
  import fft_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BITREV_LOAD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_wr_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  input  logic              core_wr_en_1,
  input  logic              core_wr_en_2,
  input  logic [ADDR_W-1:0] core_wr_addr_1,
  input  logic [ADDR_W-1:0] core_wr_addr_2,
  input  logic [DATA_W-1:0] core_wr_data_1,
  input  logic [DATA_W-1:0] core_wr_data_2,
  input  logic [ADDR_W-1:0] core_rd_addr_1,
  input  logic [ADDR_W-1:0] core_rd_addr_2,
  output logic [DATA_W-1:0] core_rd_data_1,
  output logic [DATA_W-1:0] core_rd_data_2,
  output logic              core_start,
  input  logic              core_done,
  output logic              bank_sel,
  output logic              overflow_err
);

  ctrl_t q, d;
  logic  swap;
  logic  rd_sel;

  assign swap = q.load_full & ~q.core_busy;

  always_comb begin
    d            = q;
    d.core_start = 1'b0;
    if (q.load_full && (load_done || load_wr_en))
      d.overflow_err = 1'b1;
    unique case (1'b1)
      swap: begin
        d.bank_sel   = ~q.bank_sel;
        d.core_busy  = 1'b1;
        d.load_full  = 1'b0;
        d.core_start = 1'b1;
      end
      default: begin
        if (load_done && !q.load_full) d.load_full = 1'b1;
        if (core_done) d.core_busy = 1'b0;
      end
    endcase
  end

  // rd_sel is the owner during the read cycle, so data returned just
  // after a swap still comes from the bank that was addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      rd_sel <= 1'b0;
    end else begin
      q      <= d;
      rd_sel <= q.bank_sel;
    end
  end

  assign load_ready   = ~q.load_full;
  assign core_start   = q.core_start;
  assign bank_sel     = q.bank_sel;
  assign overflow_err = q.overflow_err;

  logic              load_we;
  logic [15:0]       rev;
  logic [ADDR_W-1:0] load_wa;

  assign load_we = load_wr_en & ~q.load_full;
  assign rev     = bitrev(16'(load_addr), ADDR_W);
  assign load_wa = (BITREV_LOAD != 0) ? rev[ADDR_W-1:0] : load_addr;

  logic core_on0, core_on1, load_on0, load_on1;

  assign core_on0 = q.core_busy & ~q.bank_sel;
  assign core_on1 = q.core_busy &  q.bank_sel;
  assign load_on0 = load_we &  q.bank_sel;
  assign load_on1 = load_we & ~q.bank_sel;

  logic [DATA_W-1:0] r1_b0, r2_b0, r1_b1, r2_b1;

  fft_mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_1   (core_wr_en_1 & core_on0),
    .wr_addr_1 (core_wr_addr_1),
    .wr_data_1 (core_wr_data_1),
    .wr_en_2   (core_wr_en_2 & core_on0),
    .wr_addr_2 (core_wr_addr_2),
    .wr_data_2 (core_wr_data_2),
    .wr_en_l   (load_on0),
    .wr_addr_l (load_wa),
    .wr_data_l (load_data),
    .rd_addr_1 (core_rd_addr_1),
    .rd_addr_2 (core_rd_addr_2),
    .rd_data_1 (r1_b0),
    .rd_data_2 (r2_b0)
  );

  fft_mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_1   (core_wr_en_1 & core_on1),
    .wr_addr_1 (core_wr_addr_1),
    .wr_data_1 (core_wr_data_1),
    .wr_en_2   (core_wr_en_2 & core_on1),
    .wr_addr_2 (core_wr_addr_2),
    .wr_data_2 (core_wr_data_2),
    .wr_en_l   (load_on1),
    .wr_addr_l (load_wa),
    .wr_data_l (load_data),
    .rd_addr_1 (core_rd_addr_1),
    .rd_addr_2 (core_rd_addr_2),
    .rd_data_1 (r1_b1),
    .rd_data_2 (r2_b1)
  );

  assign core_rd_data_1 = rd_sel ? r1_b1 : r1_b0;
  assign core_rd_data_2 = rd_sel ? r2_b1 : r2_b0;

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Scoreboard bench for fft_pingpong_mem: directed scenarios plus
// randomized traffic against a bank-array reference model.
module tb_fft_pingpong_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_we = 0, ld_done = 0, core_done = 0;
  logic [3:0]  ld_addr = 0;
  logic [31:0] ld_data = 0;
  logic        we1 = 0, we2 = 0;
  logic [3:0]  wa1 = 0, wa2 = 0, ra1 = 0, ra2 = 0;
  logic [31:0] wd1 = 0, wd2 = 0;
  logic        load_ready, core_start, bank_sel, overflow_err;
  logic [31:0] rd1, rd2;

  always #5 clk = ~clk;

  fft_pingpong_mem dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_wr_en     (ld_we),
    .load_addr      (ld_addr),
    .load_data      (ld_data),
    .load_done      (ld_done),
    .load_ready     (load_ready),
    .core_wr_en_1   (we1),
    .core_wr_en_2   (we2),
    .core_wr_addr_1 (wa1),
    .core_wr_addr_2 (wa2),
    .core_wr_data_1 (wd1),
    .core_wr_data_2 (wd2),
    .core_rd_addr_1 (ra1),
    .core_rd_addr_2 (ra2),
    .core_rd_data_1 (rd1),
    .core_rd_data_2 (rd2),
    .core_start     (core_start),
    .core_done      (core_done),
    .bank_sel       (bank_sel),
    .overflow_err   (overflow_err)
  );

  typedef struct {
    logic [31:0] rd1, rd2;
    logic        bs, cs, lr, ov;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;

  logic [31:0] m [2][16];
  logic        bs = 0, lf = 0, cb = 0, ovf = 0;

  function automatic logic [3:0] br(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    exp_t e;
    logic swp;
    e.rd1 = m[bs][ra1];
    e.rd2 = m[bs][ra2];
    swp = lf && !cb;
    if (lf && (ld_done || ld_we)) ovf = 1;
    if (ld_we && !lf) m[!bs][br(ld_addr)] = ld_data;
    if (cb && we1) m[bs][wa1] = wd1;
    if (cb && we2) m[bs][wa2] = wd2;
    if (swp) begin
      bs = !bs; cb = 1; lf = 0;
    end else begin
      if (ld_done && !lf) lf = 1;
      if (core_done) cb = 0;
    end
    e.bs = bs; e.cs = swp; e.lr = !lf; e.ov = ovf;
    q.push_back(e);
    @(negedge clk);
    ld_we = 0; ld_done = 0; we1 = 0; we2 = 0; core_done = 0;
  endtask

  exp_t me;
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      me = q.pop_front();
      if (!$isunknown(me.rd1)) chk("rd_data_1", rd1, me.rd1);
      if (!$isunknown(me.rd2)) chk("rd_data_2", rd2, me.rd2);
      chk("bank_sel", {31'd0, bank_sel}, {31'd0, me.bs});
      chk("core_start", {31'd0, core_start}, {31'd0, me.cs});
      chk("load_ready", {31'd0, load_ready}, {31'd0, me.lr});
      chk("overflow_err", {31'd0, overflow_err}, {31'd0, me.ov});
    end
  end

  task automatic chk_reset_vals(string n);
    chk({n, "_bank_sel"}, {31'd0, bank_sel}, 0);
    chk({n, "_load_ready"}, {31'd0, load_ready}, 1);
    chk({n, "_core_start"}, {31'd0, core_start}, 0);
    chk({n, "_overflow"}, {31'd0, overflow_err}, 0);
    chk({n, "_rd1"}, rd1, 0);
    chk({n, "_rd2"}, rd2, 0);
  endtask

  task automatic load_frame(logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      ld_we = 1; ld_addr = 4'(i); ld_data = base + 32'(i);
      cyc();
    end
  endtask

  initial begin
    #1 rst_n = 0;
    #1 chk_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    load_frame(32'h1000);
    ld_done = 1; cyc();
    chk("swap_not_early", {31'd0, core_start}, 0);
    cyc();
    chk("load_core_start", {31'd0, core_start}, 1);
    chk("load_bank_sel", {31'd0, bank_sel}, 1);
    ra1 = 4'd8; cyc();
    chk("bitrev_rd8", rd1, 32'h1001);
    chk("start_one_cycle", {31'd0, core_start}, 0);

    we1 = 1; we2 = 1; wa1 = 5; wa2 = 5;
    wd1 = 32'hAAAA; wd2 = 32'hBBBB; ra1 = 5;
    cyc();
    chk("rbw_old", rd1, 32'h1000 + 32'(br(4'd5)));
    cyc();
    chk("collision", rd1, 32'hBBBB);

    load_frame(32'h2000);
    ld_done = 1; cyc();
    cyc();
    chk("ovf_ready", {31'd0, load_ready}, 0);
    ld_we = 1; ld_addr = 0; ld_data = 32'hDEAD; cyc();
    chk("ovf_flag", {31'd0, overflow_err}, 1);
    core_done = 1; cyc();
    chk("ovf_no_swap_yet", {31'd0, bank_sel}, 1);
    cyc();
    chk("ovf_swap_back", {31'd0, bank_sel}, 0);
    ra1 = 0; cyc();
    chk("dropped_write", rd1, 32'h2000);

    core_done = 1; ld_done = 1; cyc();
    chk("sim_no_swap", {31'd0, core_start}, 0);
    cyc();
    chk("sim_swap", {31'd0, core_start}, 1);
    chk("sim_bank", {31'd0, bank_sel}, 1);
    cyc();
    chk("sim_start_width", {31'd0, core_start}, 0);

    for (int i = 0; i < 4; i++) begin
      we1 = 1; wa1 = 4'(i); wd1 = $urandom; cyc();
    end
    we1 = 1; wa1 = 9; wd1 = 32'h5555;
    rst_n = 0;
    #1 chk_reset_vals("midrst");
    bs = 0; lf = 0; cb = 0; ovf = 0;
    @(negedge clk); @(negedge clk);
    we1 = 0;
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i); cyc();
      chk("no_start_after_rst", {31'd0, core_start}, 0);
    end

    for (int i = 0; i < 1500; i++) begin
      ld_we   = (!lf || $urandom_range(0, 19) == 0);
      ld_addr = 4'($urandom); ld_data = $urandom;
      ld_done = ($urandom_range(0, 17) == 0);
      we1 = ($urandom_range(0, 9) < 4); wa1 = 4'($urandom); wd1 = $urandom;
      we2 = ($urandom_range(0, 9) < 4); wa2 = 4'($urandom); wd2 = $urandom;
      if ($urandom_range(0, 7) == 0) wa2 = wa1;
      ra1 = 4'($urandom); ra2 = 4'($urandom);
      core_done = ($urandom_range(0, 14) == 0);
      cyc();
    end

    @(negedge clk); @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
